// File: rtl/alu_exe_unit_pkg.sv
// Shared widths, ALU command codes and forwarding select codes for the EXE stage.
package alu_exe_unit_pkg;
  localparam int WORD_LEN     = 32;
  localparam int EXE_CMD_LEN  = 4;
  localparam int FORW_SEL_LEN = 2;
  localparam int NUM_FWD      = 3;

  typedef enum logic [EXE_CMD_LEN-1:0] {
    EXE_ADD  = 4'b0000,
    EXE_SUB  = 4'b0010,
    EXE_AND  = 4'b0100,
    EXE_OR   = 4'b0101,
    EXE_NOR  = 4'b0110,
    EXE_XOR  = 4'b0111,
    EXE_SLL  = 4'b1000,
    EXE_SRA  = 4'b1001,
    EXE_SRL  = 4'b1010,
    EXE_SLLI = 4'b1011,
    EXE_NOP  = 4'b1111
  } exe_cmd_e;

  typedef enum logic [FORW_SEL_LEN-1:0] {
    FORW_ID  = 2'd0,
    FORW_MEM = 2'd1,
    FORW_WB  = 2'd2
  } forw_sel_e;
endpackage

// File: rtl/alu_exe_unit_alu.sv
// Combinational ALU: 32-bit wrapping arithmetic/logic/shift, no flags.
module ALU
  import alu_exe_unit_pkg::*;
(
  input  logic [WORD_LEN-1:0]    val1,
  input  logic [WORD_LEN-1:0]    val2,
  input  logic [7:0]             SLLAmount,
  input  logic [EXE_CMD_LEN-1:0] EXE_CMD,
  output logic [WORD_LEN-1:0]    aluOut
);
  logic [4:0]          shamt;
  logic [WORD_LEN-6:0] unused_shamt_hi;

  // Register-operand shifts only honour the low five bits of b.
  assign shamt           = val2[4:0];
  assign unused_shamt_hi = val2[WORD_LEN-1:5];

  always_comb begin
    aluOut = '0;
    case (EXE_CMD)
      EXE_ADD:  aluOut = val1 + val2;
      EXE_SUB:  aluOut = val1 - val2;
      EXE_AND:  aluOut = val1 & val2;
      EXE_OR:   aluOut = val1 | val2;
      EXE_NOR:  aluOut = ~(val1 | val2);
      EXE_XOR:  aluOut = val1 ^ val2;
      EXE_SLL:  aluOut = val1 << shamt;
      EXE_SRA:  aluOut = $unsigned($signed(val1) >>> shamt);
      EXE_SRL:  aluOut = val1 >> shamt;
      EXE_SLLI: aluOut = (SLLAmount >= 8'd32) ? '0 : (val1 << SLLAmount[4:0]);
      default:  aluOut = '0;
    endcase
  end
endmodule

// File: rtl/alu_exe_unit_mux.sv
// Three-way forwarding mux: ID/EXE value, MEM-stage result or WB result.
module mux_3input
  import alu_exe_unit_pkg::*;
#(
  parameter int LENGTH = WORD_LEN
) (
  input  logic [LENGTH-1:0]       in1,
  input  logic [LENGTH-1:0]       in2,
  input  logic [LENGTH-1:0]       in3,
  input  logic [FORW_SEL_LEN-1:0] sel,
  output logic [LENGTH-1:0]       out
);
  // Unused select code 3 falls back to the ID/EXE value.
  always_comb begin
    out = in1;
    case (sel)
      FORW_MEM: out = in2;
      FORW_WB:  out = in3;
      default:  out = in1;
    endcase
  end
endmodule

// File: rtl/alu_exe_unit.sv
// EXE stage: operand/store forwarding, ALU, and the EXE/MEM output register.
module alu_exe_unit
  import alu_exe_unit_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [EXE_CMD_LEN-1:0]  EXE_CMD,
  input  logic [FORW_SEL_LEN-1:0] val1_sel,
  input  logic [FORW_SEL_LEN-1:0] val2_sel,
  input  logic [FORW_SEL_LEN-1:0] ST_val_sel,
  input  logic [WORD_LEN-1:0]     val1,
  input  logic [WORD_LEN-1:0]     val2,
  input  logic [WORD_LEN-1:0]     ST_value_in,
  input  logic [WORD_LEN-1:0]     ALU_res_MEM,
  input  logic [WORD_LEN-1:0]     result_WB,
  input  logic [7:0]              SLLAmount,
  output logic [WORD_LEN-1:0]     ALUResult,
  output logic [WORD_LEN-1:0]     ST_value_out,
  output logic [WORD_LEN-1:0]     ALUResult_q,
  output logic [WORD_LEN-1:0]     ST_value_q
);
  // Slot 0: operand 1, slot 1: operand 2, slot 2: store value.
  logic [NUM_FWD-1:0][WORD_LEN-1:0]     fwd_id;
  logic [NUM_FWD-1:0][WORD_LEN-1:0]     fwd_out;
  logic [NUM_FWD-1:0][FORW_SEL_LEN-1:0] fwd_sel;

  assign fwd_id  = {ST_value_in, val2, val1};
  assign fwd_sel = {ST_val_sel, val2_sel, val1_sel};

  for (genvar i = 0; i < NUM_FWD; i++) begin : g_fwd
    mux_3input #(.LENGTH(WORD_LEN)) u_mux (
      .in1 (fwd_id[i]),
      .in2 (ALU_res_MEM),
      .in3 (result_WB),
      .sel (fwd_sel[i]),
      .out (fwd_out[i])
    );
  end

  ALU u_alu (
    .val1      (fwd_out[0]),
    .val2      (fwd_out[1]),
    .SLLAmount (SLLAmount),
    .EXE_CMD   (EXE_CMD),
    .aluOut    (ALUResult)
  );

  assign ST_value_out = fwd_out[2];

  always_ff @(posedge clk) begin
    if (rst) begin
      ALUResult_q <= '0;
      ST_value_q  <= '0;
    end else begin
      ALUResult_q <= ALUResult;
      ST_value_q  <= ST_value_out;
    end
  end
endmodule

// File: tb/tb_alu_exe_unit.sv
// Directed bench for alu_exe_unit: forwarding, ALU ops, shifts, store path and register reset.
module tb_alu_exe_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  EXE_CMD;
  logic [1:0]  val1_sel, val2_sel, ST_val_sel;
  logic [31:0] val1, val2, ST_value_in, ALU_res_MEM, result_WB;
  logic [7:0]  SLLAmount;
  logic [31:0] ALUResult, ST_value_out, ALUResult_q, ST_value_q;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  alu_exe_unit dut (
    .clk          (clk),
    .rst          (rst),
    .EXE_CMD      (EXE_CMD),
    .val1_sel     (val1_sel),
    .val2_sel     (val2_sel),
    .ST_val_sel   (ST_val_sel),
    .val1         (val1),
    .val2         (val2),
    .ST_value_in  (ST_value_in),
    .ALU_res_MEM  (ALU_res_MEM),
    .result_WB    (result_WB),
    .SLLAmount    (SLLAmount),
    .ALUResult    (ALUResult),
    .ST_value_out (ST_value_out),
    .ALUResult_q  (ALUResult_q),
    .ST_value_q   (ST_value_q)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic alu(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b);
    EXE_CMD = cmd; val1 = a; val2 = b; val1_sel = 2'd0; val2_sel = 2'd0;
    #1;
  endtask

  initial begin
    rst = 1'b1; EXE_CMD = 4'b0000; val1_sel = 2'd0; val2_sel = 2'd0; ST_val_sel = 2'd0;
    val1 = 32'd0; val2 = 32'd0; ST_value_in = 32'd0; ALU_res_MEM = 32'd0;
    result_WB = 32'd0; SLLAmount = 8'd0;
    @(posedge clk); #1;
    check("reset_alu_q", ALUResult_q, 32'd0);
    check("reset_st_q", ST_value_q, 32'd0);
    rst = 1'b0;

    // Forwarding on operand 1
    val1 = 32'd5; val2 = 32'd0; ALU_res_MEM = 32'd7; result_WB = 32'd9; EXE_CMD = 4'b0000;
    val1_sel = 2'd0; #1; check("fwd1_sel0", ALUResult, 32'd5);
    val1_sel = 2'd1; #1; check("fwd1_sel1", ALUResult, 32'd7);
    val1_sel = 2'd2; #1; check("fwd1_sel2", ALUResult, 32'd9);
    val1_sel = 2'd3; #1; check("fwd1_sel3", ALUResult, 32'd5);
    // Forwarding on operand 2: 5 - 7 and 5 - 9
    val1_sel = 2'd0; EXE_CMD = 4'b0010;
    val2_sel = 2'd1; #1; check("fwd2_mem_sub", ALUResult, 32'hFFFF_FFFE);
    val2_sel = 2'd2; #1; check("fwd2_wb_sub", ALUResult, 32'hFFFF_FFFC);

    alu(4'b0000, 32'hFFFF_FFFF, 32'd1);          check("add_wrap", ALUResult, 32'h0);
    alu(4'b0010, 32'd3, 32'd5);                  check("sub_neg", ALUResult, 32'hFFFF_FFFE);
    alu(4'b0110, 32'd0, 32'd0);                  check("nor_zero", ALUResult, 32'hFFFF_FFFF);
    alu(4'b0100, 32'hF0F0_00FF, 32'h0FF0_0F0F);  check("and", ALUResult, 32'h00F0_000F);
    alu(4'b0101, 32'hF0F0_00FF, 32'h0FF0_0F0F);  check("or", ALUResult, 32'hFFF0_0FFF);
    alu(4'b0111, 32'hF0F0_00FF, 32'h0FF0_0F0F);  check("xor", ALUResult, 32'hFF00_0FF0);
    alu(4'b1001, 32'h8000_0000, 32'd4);          check("sra", ALUResult, 32'hF800_0000);
    alu(4'b1010, 32'h8000_0000, 32'd4);          check("srl", ALUResult, 32'h0800_0000);
    alu(4'b1001, 32'h8000_0000, 32'h0000_0024);  check("sra_mask", ALUResult, 32'hF800_0000);
    alu(4'b1000, 32'd1, 32'h0000_0021);          check("sll_mask", ALUResult, 32'd2);
    SLLAmount = 8'd40;
    alu(4'b1011, 32'd1, 32'd0);                  check("slli_40", ALUResult, 32'd0);
    SLLAmount = 8'd32; #1;                       check("slli_32", ALUResult, 32'd0);
    SLLAmount = 8'd3; #1;                        check("slli_3", ALUResult, 32'd8);
    SLLAmount = 8'd31; #1;                       check("slli_31", ALUResult, 32'h8000_0000);
    alu(4'b0011, 32'd12, 32'd34);                check("illegal_0011", ALUResult, 32'd0);
    alu(4'b1111, 32'd12, 32'd34);                check("nop", ALUResult, 32'd0);

    // Store forwarding and the EXE/MEM register
    ST_value_in = 32'h1111; result_WB = 32'hDEAD; ALU_res_MEM = 32'hBEEF;
    ST_val_sel = 2'd2;
    alu(4'b0000, 32'h10, 32'h20);
    check("st_fwd_wb", ST_value_out, 32'hDEAD);
    check("alu_pre_reg", ALUResult, 32'h30);
    @(posedge clk); #1;
    check("st_q", ST_value_q, 32'hDEAD);
    check("alu_q", ALUResult_q, 32'h30);
    ST_val_sel = 2'd1; #1; check("st_fwd_mem", ST_value_out, 32'hBEEF);
    ST_val_sel = 2'd3; #1; check("st_fwd_sel3", ST_value_out, 32'h1111);
    check("st_q_hold", ST_value_q, 32'hDEAD);

    // Mid-stream reset clears only the registers
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_alu_q", ALUResult_q, 32'd0);
    check("rst_st_q", ST_value_q, 32'd0);
    check("rst_comb_alu", ALUResult, 32'h30);
    check("rst_comb_st", ST_value_out, 32'h1111);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_alu_q", ALUResult_q, 32'h30);
    check("post_rst_st_q", ST_value_q, 32'h1111);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
